// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI3 responder over a word-organised single-port SRAM, one transaction at a time.
module axi_sram_responder #(
    parameter int AXI_WIDTH_SID = 8,
    parameter int AXI_WIDTH_AD  = 32,
    parameter int AXI_WIDTH_DA  = 32,
    parameter int AXI_WIDTH_DS  = AXI_WIDTH_DA / 8,
    parameter int MEM_DEPTH     = 1024
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [AXI_WIDTH_SID-1:0] AWID,
    input  logic [AXI_WIDTH_AD-1:0]  AWADDR,
    input  logic [3:0]               AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [AXI_WIDTH_SID-1:0] WID,
    input  logic [AXI_WIDTH_DA-1:0]  WDATA,
    input  logic [AXI_WIDTH_DS-1:0]  WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [AXI_WIDTH_SID-1:0] BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [AXI_WIDTH_SID-1:0] ARID,
    input  logic [AXI_WIDTH_AD-1:0]  ARADDR,
    input  logic [3:0]               ARLEN,
    input  logic [2:0]               ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [AXI_WIDTH_SID-1:0] RID,
    output logic [AXI_WIDTH_DA-1:0]  RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY
);
    localparam int OFF = $clog2(AXI_WIDTH_DS);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [AXI_WIDTH_AD-1:0] ONE = AXI_WIDTH_AD'(1);

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA} state_t;

    state_t                    state;
    logic                      prio;
    logic [AXI_WIDTH_SID-1:0]  id;
    logic [AXI_WIDTH_AD-1:0]   addr;
    logic [3:0]                len;
    logic [3:0]                cnt;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      discard;
    logic                      err;
    logic [AXI_WIDTH_DA-1:0]   mem [MEM_DEPTH];
    logic [AXI_WIDTH_DA-1:0]   rdata;

    logic                      aw_go;
    logic                      ar_go;
    logic                      last;
    logic [AXI_WIDTH_SID-1:0]  a_id;
    logic [AXI_WIDTH_AD-1:0]   a_addr;
    logic [3:0]                a_len;
    logic [2:0]                a_size;
    logic [1:0]                a_burst;
    logic                      a_bad;
    logic                      a_wrap_bad;
    logic [AXI_WIDTH_AD-1:0]   sz;
    logic [AXI_WIDTH_AD-1:0]   bnd;
    logic [AXI_WIDTH_AD-1:0]   nxt;
    logic [IW-1:0]             idx;

    // prio = 0 favours the write channel when both address channels are valid
    assign AWREADY = !ARESET && state == IDLE && AWVALID && (!ARVALID || !prio);
    assign ARREADY = !ARESET && state == IDLE && ARVALID && (!AWVALID || prio);
    assign aw_go = AWVALID && AWREADY;
    assign ar_go = ARVALID && ARREADY;
    assign WREADY = state == WR_DATA;
    assign BVALID = state == WR_RESP;
    assign RVALID = state == RD_DATA;
    assign last = cnt == len;
    assign RLAST = RVALID && last;
    assign BID = id;
    assign RID = id;
    assign BRESP = {err, 1'b0};
    assign RRESP = {err, 1'b0};
    assign RDATA = rdata;
    assign idx = addr[OFF+IW-1:OFF];

    always_comb begin
        a_id = aw_go ? AWID : ARID;
        a_addr = aw_go ? AWADDR : ARADDR;
        a_len = aw_go ? AWLEN : ARLEN;
        a_size = aw_go ? AWSIZE : ARSIZE;
        a_burst = aw_go ? AWBURST : ARBURST;
        a_bad = a_burst == 2'b11 || 32'(a_size) > OFF;
        a_wrap_bad = a_burst == 2'b10 && !(a_len inside {4'd1, 4'd3, 4'd7, 4'd15});
        sz = ONE << size;
        bnd = (AXI_WIDTH_AD'(len) + ONE) << size;
        nxt = burst == 2'b00 ? addr :
              burst == 2'b10 ? (addr & ~(bnd - ONE)) | ((addr + sz) & (bnd - ONE)) :
                               (addr & ~(sz - ONE)) + sz;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
            prio <= 1'b0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (aw_go || ar_go) begin
                    state <= aw_go ? WR_DATA : RD_FETCH;
                    prio <= aw_go;
                    id <= a_id;
                    addr <= a_addr;
                    len <= a_len;
                    size <= a_size;
                    burst <= a_wrap_bad ? 2'b01 : a_burst;
                    discard <= a_bad;
                    err <= a_bad || a_wrap_bad;
                    cnt <= '0;
                end
                WR_DATA: if (WVALID) begin
                    err <= err || (WLAST != last) || (WID != id);
                    cnt <= cnt + 4'd1;
                    addr <= nxt;
                    if (last) state <= WR_RESP;
                end
                WR_RESP: if (BREADY) state <= IDLE;
                RD_FETCH: state <= RD_DATA;
                RD_DATA: if (RREADY) begin
                    if (last) begin
                        state <= IDLE;
                    end else begin
                        state <= RD_FETCH;
                        cnt <= cnt + 4'd1;
                        addr <= nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // discarded bursts (reserved burst or oversized beat) never touch the array
    always_ff @(posedge ACLK) begin
        if (state == WR_DATA && WVALID && !discard && !ARESET)
            for (int b = 0; b < AXI_WIDTH_DS; b++)
                if (WSTRB[b]) mem[idx][8*b +: 8] <= WDATA[8*b +: 8];
        if (state == RD_FETCH) rdata <= discard ? '0 : mem[idx];
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: randomized scoreboard bench with a transaction-level memory model.
module tb_axi_sram_responder;
    logic        ACLK = 0, ARESET = 1;
    logic [7:0]  AWID = 0, WID = 0, BID, ARID = 0, RID;
    logic [31:0] AWADDR = 0, ARADDR = 0, WDATA = 0, RDATA;
    logic [3:0]  AWLEN = 0, ARLEN = 0, WSTRB = 0;
    logic [2:0]  AWSIZE = 0, ARSIZE = 0;
    logic [1:0]  AWBURST = 0, ARBURST = 0, BRESP, RRESP;
    logic        AWVALID = 0, AWREADY, WLAST = 0, WVALID = 0, WREADY, BVALID, BREADY = 0;
    logic        ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0;

    axi_sram_responder dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit rd; bit [7:0] id; bit [1:0] resp; bit [31:0] data; bit last;
    } exp_t;
    typedef struct {
        bit [7:0] id; bit [31:0] addr; bit [3:0] len; bit [2:0] size; bit [1:0] burst;
        int bad_last; int bad_id;
    } txn_t;

    exp_t      q[$];
    int        n_cmp = 0, n_bad = 0;
    bit [31:0] mm [1024];
    bit [31:0] wd [16];
    bit [3:0]  ws [16];
    bit        mprio = 0;
    bit        manual_ready = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic bit is_bad(bit [1:0] burst, bit [2:0] size);
        return burst == 2'b11 || size > 3'd2;
    endfunction

    function automatic bit wrap_bad(bit [1:0] burst, bit [3:0] len);
        return burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
    endfunction

    // closed-form byte address of beat i
    function automatic bit [31:0] baddr(txn_t t, int i);
        bit [31:0] sz = 32'd1 << t.size;
        bit [31:0] bnd = (32'(t.len) + 1) * sz;
        bit [1:0] b = wrap_bad(t.burst, t.len) ? 2'b01 : t.burst;
        if (b == 2'b00 || b == 2'b11) return t.addr;
        if (b == 2'b10) return (t.addr & ~(bnd - 1)) | ((t.addr + i * sz) & (bnd - 1));
        return i == 0 ? t.addr : (t.addr & ~(sz - 1)) + i * sz;
    endfunction

    function automatic int widx(bit [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    task automatic model_write(input txn_t t);
        bit e = is_bad(t.burst, t.size) || wrap_bad(t.burst, t.len);
        for (int i = 0; i <= int'(t.len); i++) begin
            if (t.bad_last == i || t.bad_id == i) e = 1;
            if (!is_bad(t.burst, t.size))
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mm[widx(baddr(t, i))][8*b +: 8] = wd[i][8*b +: 8];
        end
        q.push_back('{rd: 1'b0, id: t.id, resp: e ? 2'b10 : 2'b00, data: 32'd0, last: 1'b0});
        mprio = 1;
    endtask

    task automatic model_read(input txn_t t);
        bit e = is_bad(t.burst, t.size) || wrap_bad(t.burst, t.len);
        for (int i = 0; i <= int'(t.len); i++)
            q.push_back('{rd: 1'b1, id: t.id, resp: e ? 2'b10 : 2'b00,
                          data: is_bad(t.burst, t.size) ? 32'd0 : mm[widx(baddr(t, i))],
                          last: i == int'(t.len)});
        mprio = 0;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_hs(input int w, input string nm);
        int t = 0;
        forever begin
            @(negedge ACLK);
            if ((w == 0 && AWREADY) || (w == 1 && WREADY) || (w == 2 && ARREADY) || (w == 3 && RVALID)) break;
            if (++t > 600) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_timeout: no response after %0d cycles, want one", nm, t);
                break;
            end
        end
    endtask

    task automatic drive_aw(input txn_t t);
        tick();
        AWID = t.id; AWADDR = t.addr; AWLEN = t.len; AWSIZE = t.size; AWBURST = t.burst;
        AWVALID = 1;
        wait_hs(0, "aw");
        tick();
        AWVALID = 0;
    endtask

    task automatic drive_w(input txn_t t);
        for (int i = 0; i <= int'(t.len); i++) begin
            WID = t.bad_id == i ? t.id ^ 8'h01 : t.id;
            WDATA = wd[i];
            WSTRB = ws[i];
            WLAST = (i == int'(t.len)) ^ (i == t.bad_last);
            WVALID = 1;
            wait_hs(1, "w");
            tick();
        end
        WVALID = 0;
        WLAST = 0;
    endtask

    task automatic drive_ar(input txn_t t);
        tick();
        ARID = t.id; ARADDR = t.addr; ARLEN = t.len; ARSIZE = t.size; ARBURST = t.burst;
        ARVALID = 1;
        wait_hs(2, "ar");
        tick();
        ARVALID = 0;
    endtask

    task automatic do_write(input txn_t t);
        model_write(t);
        drive_aw(t);
        drive_w(t);
    endtask

    task automatic do_read(input txn_t t);
        model_read(t);
        drive_ar(t);
    endtask

    task automatic do_pair(input txn_t tw, input txn_t tr);
        if (!mprio) begin
            model_write(tw);
            model_read(tr);
        end else begin
            model_read(tr);
            model_write(tw);
        end
        fork
            begin drive_aw(tw); drive_w(tw); end
            drive_ar(tr);
        join
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 4000) begin
            @(negedge ACLK);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, want 0", q.size());
            q.delete();
        end
        tick();
    endtask

    function automatic txn_t mk(bit [7:0] id, bit [31:0] a, bit [3:0] len, bit [2:0] size, bit [1:0] burst);
        return '{id: id, addr: a, len: len, size: size, burst: burst, bad_last: -1, bad_id: -1};
    endfunction

    task automatic rand_txn(output txn_t t);
        t.id = 8'($urandom);
        t.addr = $urandom;
        t.len = 4'($urandom_range(0, 15));
        t.size = $urandom_range(0, 9) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
        t.burst = $urandom_range(0, 9) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
        t.bad_last = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, int'(t.len))) : -1;
        t.bad_id = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, int'(t.len))) : -1;
        for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'($urandom);
        end
    endtask

    // monitor: pops one expectation per B or R handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (!ARESET && BVALID && BREADY) begin
                if (q.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    chk("b_order", 64'(e.rd), 64'd0);
                    chk("bid", 64'(BID), 64'(e.id));
                    chk("bresp", 64'(BRESP), 64'(e.resp));
                end
            end
            if (!ARESET && RVALID && RREADY) begin
                if (q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    chk("r_order", 64'(e.rd), 64'd1);
                    chk("rid", 64'(RID), 64'(e.id));
                    chk("rresp", 64'(RRESP), 64'(e.resp));
                    chk("rdata", 64'(RDATA), 64'(e.data));
                    chk("rlast", 64'(RLAST), 64'(e.last));
                end
            end
        end
    end

    initial forever begin
        tick();
        if (!manual_ready) begin
            BREADY = $urandom_range(0, 3) != 0;
            RREADY = $urandom_range(0, 3) != 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t tw, tr;
        ARESET = 1;
        AWVALID = 1;
        ARVALID = 1;
        repeat (2) tick();
        @(negedge ACLK);
        chk("rst_awready", 64'(AWREADY), 0);
        chk("rst_arready", 64'(ARREADY), 0);
        chk("rst_wready", 64'(WREADY), 0);
        chk("rst_bvalid", 64'(BVALID), 0);
        chk("rst_rvalid", 64'(RVALID), 0);
        chk("rst_rlast", 64'(RLAST), 0);
        chk("rst_bresp", 64'(BRESP), 0);
        chk("rst_rresp", 64'(RRESP), 0);
        tick();
        AWVALID = 0;
        ARVALID = 0;
        ARESET = 0;
        mprio = 0;

        // simultaneous request straight after reset: write wins
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        do_pair(mk(8'h11, 32'h100, 0, 2, 1), mk(8'h22, 32'h100, 0, 2, 1));
        drain();

        for (int k = 0; k < 64; k++) begin
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'hF;
            end
            do_write(mk(8'($urandom), 32'(k * 64), 15, 2, 1));
        end
        drain();

        // last grant was a write, so the next contested pair favours the read
        wd[0] = 32'h0BADBEEF; ws[0] = 4'hF;
        do_pair(mk(8'h33, 32'h300, 0, 2, 1), mk(8'h44, 32'h300, 1, 2, 1));
        drain();

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i + 1);
            ws[i] = 4'hF;
        end
        do_write(mk(8'h3C, 32'h10, 3, 2, 1));
        do_read(mk(8'h3D, 32'h10, 3, 2, 1));
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(mk(8'h01, 32'h20, 0, 2, 1));
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        do_write(mk(8'h02, 32'h20, 0, 2, 1));
        do_read(mk(8'h03, 32'h20, 0, 2, 1));
        do_read(mk(8'h04, 32'h38, 3, 2, 2));
        do_read(mk(8'h05, 32'h44, 2, 2, 0));
        tw = mk(8'h06, 32'h80, 1, 2, 1);
        tw.bad_last = 0;
        wd[0] = 32'h55555555; wd[1] = 32'h66666666; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(tw);
        do_read(mk(8'h07, 32'h80, 1, 2, 1));
        do_write(mk(8'h08, 32'h10, 3, 2, 3));
        do_read(mk(8'h09, 32'h10, 3, 2, 1));
        drain();

        for (int n = 0; n < 120; n++) begin
            rand_txn(tw);
            if (n % 10 == 9) begin
                rand_txn(tr);
                drain();
                do_pair(tw, tr);
            end else if ($urandom_range(0, 1) == 0) do_write(tw);
            else do_read(tw);
        end
        drain();

        // reset while beat 2 of a 4-beat read is presented
        manual_ready = 1;
        BREADY = 1;
        RREADY = 1;
        tr = mk(8'h77, 32'h10, 3, 2, 1);
        model_read(tr);
        repeat (3) void'(q.pop_back());
        drive_ar(tr);
        wait_hs(3, "r_beat1");
        tick();
        RREADY = 0;
        wait_hs(3, "r_beat2");
        ARESET = 1;
        tick();
        ARESET = 0;
        mprio = 0;
        @(negedge ACLK);
        chk("abort_rvalid", 64'(RVALID), 0);
        chk("abort_rlast", 64'(RLAST), 0);
        chk("abort_pending", 64'(q.size()), 0);
        repeat (3) tick();
        @(negedge ACLK);
        chk("abort_rvalid_later", 64'(RVALID), 0);
        manual_ready = 0;
        wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(mk(8'h78, 32'h40, 1, 2, 1));
        do_read(mk(8'h79, 32'h40, 1, 2, 1));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
